// File: rtl/shift_pkg.sv
// Shared definitions for the shift datapath and its operand deserializer.
// Frame length depends on OPDES_PARITY_EN (one trailing even-parity bit).
package shift_pkg;

  localparam int unsigned SHIFT_WIDTH = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } opdes_state_e;

  // Serial frame length in bits for a given operand width
  function automatic int unsigned frame_len(input int unsigned width);
`ifdef OPDES_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/opdes_bitcnt.sv
// Frame bit counter: counts enabled cycles modulo FRAME, flags the last bit
// combinationally and reports a registered "count is non-zero" status.
module opdes_bitcnt #(
  parameter int unsigned FRAME = 8,
  localparam int unsigned CW = (FRAME > 1) ? $clog2(FRAME) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tc_c,
  output logic busy_o
);

  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;

  always_comb begin
    tc_c  = en_i && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = tc_c ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/operand_deserializer.sv
// Serial-to-parallel operand loader with a held output word and valid/ready handshake.
// Define OPDES_PARITY_EN to append and check an even-parity bit per frame.
module operand_deserializer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic [WIDTH-1:0] a_out,
  output logic             a_valid,
  input  logic             a_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned FRAME = frame_len(WIDTH);

  logic             tc_c;
  logic             word_ok_c;
  logic [WIDTH-1:0] word_c;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] a_out_q, a_out_d;
  logic             overrun_q, overrun_d;
  opdes_state_e     state_q, state_d;

  opdes_bitcnt #(.FRAME(FRAME)) u_bitcnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (ser_valid),
    .tc_c   (tc_c),
    .busy_o (busy)
  );

`ifdef OPDES_PARITY_EN
  logic perr_q, perr_d;

  // The parity bit is compared against the held data rather than shifted in
  always_comb begin
    shreg_d = shreg_q;
    if (ser_valid && !tc_c) begin
      shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
    end
  end

  assign word_c    = shreg_q;
  assign word_ok_c = tc_c && ((^shreg_q ^ ser_in) == 1'b0);
  assign perr_d    = tc_c && !word_ok_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  always_comb begin
    shreg_d = shreg_q;
    if (ser_valid) begin
      shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
    end
  end

  assign word_c     = shreg_d;
  assign word_ok_c  = tc_c;
  assign parity_err = 1'b0;
`endif

  // Output register FSM; a completion while FULL and stalled drops the new word
  always_comb begin
    state_d   = state_q;
    a_out_d   = a_out_q;
    overrun_d = 1'b0;
    case (state_q)
      EMPTY: begin
        if (word_ok_c) begin
          state_d = FULL;
          a_out_d = word_c;
        end
      end
      FULL: begin
        if (word_ok_c) begin
          if (a_ready) begin
            a_out_d = word_c;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (a_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      shreg_q   <= '0;
      a_out_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      a_out_q   <= a_out_d;
      overrun_q <= overrun_d;
    end
  end

  assign a_out   = a_out_q;
  assign a_valid = (state_q == FULL);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_operand_deserializer.sv
// Directed self-checking bench for operand_deserializer (both parity builds).
module tb_operand_deserializer;

`ifdef OPDES_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk;
  logic       rst;
  logic       ser_in;
  logic       ser_valid;
  logic [7:0] a_out;
  logic       a_valid;
  logic       a_ready;
  logic       busy;
  logic       overrun;
  logic       parity_err;

  int checks;
  int failures;

  operand_deserializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .a_out      (a_out),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp_out, input logic exp_valid,
                         input logic exp_ovr, input logic exp_perr);
    chk({tag, "_a_out"},   a_out,           exp_out);
    chk({tag, "_a_valid"}, 8'(a_valid),     8'(exp_valid));
    chk({tag, "_busy"},    8'(busy),        8'h00);
    chk({tag, "_overrun"}, 8'(overrun),     8'(exp_ovr));
    chk({tag, "_perr"},    8'(parity_err),  8'(exp_perr));
  endtask

  // Send one frame LSB first; returns at the negedge right after the last bit is sampled
  task automatic send_word(input logic [7:0] w, input int gap, input bit chk_busy,
                           input bit bad_par, input bit rdy_last);
    logic [8:0] f;
    f = {(^w) ^ bad_par, w};
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      ser_valid = 1'b1;
      ser_in    = f[i];
      if (rdy_last && i == FRAME - 1) a_ready = 1'b1;
      if (i < FRAME - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          ser_valid = 1'b0;
          if (chk_busy) chk("gap_busy", 8'(busy), 8'h01);
        end
      end
    end
    @(negedge clk);
    ser_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    ser_valid = 1'b1;
    ser_in    = 1'b0;
    a_ready   = 1'b0;

    // Reset held two cycles with live serial input
    repeat (2) begin
      @(negedge clk);
      chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      ser_in = 1'($urandom_range(0, 1));
    end
    rst       = 1'b0;
    ser_valid = 1'b0;
    a_ready   = 1'b1;

    // Basic word: bits 1,0,1,0,0,1,0,1
    send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    chk_out("basic", 8'hA5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("basic_drop", 8'(a_valid), 8'h00);

    // Gapped input
    send_word(8'h3C, 3, 1'b1, 1'b0, 1'b0);
    chk_out("gapped", 8'h3C, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("gapped_drop", 8'(a_valid), 8'h00);

    // Overrun: second word dropped while the first is stalled
    a_ready = 1'b0;
    send_word(8'h3C, 0, 1'b0, 1'b0, 1'b0);
    chk_out("ovr_first", 8'h3C, 1'b1, 1'b0, 1'b0);
    send_word(8'hC3, 0, 1'b0, 1'b0, 1'b0);
    chk_out("ovr_second", 8'h3C, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_out("ovr_after", 8'h3C, 1'b1, 1'b0, 1'b0);
    a_ready = 1'b1;
    @(negedge clk);
    chk("ovr_drain_valid", 8'(a_valid), 8'h00);
    chk("ovr_drain_pulse", 8'(overrun), 8'h00);

    // Completion and consumption in the same cycle
    a_ready = 1'b0;
    send_word(8'h11, 0, 1'b0, 1'b0, 1'b0);
    chk_out("simul_hold", 8'h11, 1'b1, 1'b0, 1'b0);
    send_word(8'h22, 0, 1'b0, 1'b0, 1'b1);
    chk_out("simul_swap", 8'h22, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("simul_drain", 8'(a_valid), 8'h00);

    // Reset after four bits discards the partial frame
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ser_valid = 1'b1;
      ser_in    = 1'b1;
    end
    @(negedge clk);
    chk("mid_busy", 8'(busy), 8'h01);
    rst       = 1'b1;
    ser_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 8'(busy), 8'h00);
    chk("mid_rst_valid", 8'(a_valid), 8'h00);
    send_word(8'h81, 0, 1'b0, 1'b0, 1'b0);
    chk_out("mid_word", 8'h81, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_drain", 8'(a_valid), 8'h00);

`ifdef OPDES_PARITY_EN
    // 8'h81 has even weight; a parity bit of 1 must be rejected
    send_word(8'h81, 0, 1'b0, 1'b1, 1'b0);
    chk("par_err_pulse", 8'(parity_err), 8'h01);
    chk("par_err_valid", 8'(a_valid), 8'h00);
    chk("par_err_ovr", 8'(overrun), 8'h00);
    @(negedge clk);
    chk("par_err_clear", 8'(parity_err), 8'h00);
    chk("par_err_valid2", 8'(a_valid), 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_deserializer.md
# operand_deserializer

Serial-to-parallel operand loader for the shift datapath. It collects operand bits from a 1-bit serial stream and assembles them into a WIDTH-bit word. The word is presented to the downstream shift stage's `A` input through a valid/ready handshake. A double-buffered output register allows the next word to be collected while the current one waits to be consumed.

## Interface
Clock is `clk`. Reset is `rst`, synchronous and active-high. All other ports are registered on `clk`.

Parameters:
- `WIDTH`, default 8: operand width. Must equal the shift stage's `A` width.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `ser_in`  in  1  serial data bit, LSB first
- `ser_valid`  in  1  `ser_in` is sampled this cycle
- `a_out`  out  WIDTH  assembled operand; drives shift stage `A`
- `a_valid`  out  1  `a_out` holds an unconsumed word
- `a_ready`  in  1  downstream accepts `a_out` this cycle
- `busy`  out  1  a partial word is in the shift register (bit count ≠ 0)
- `overrun`  out  1  one-cycle pulse: a completed word was dropped
- `parity_err`  out  1  one-cycle pulse: parity failure; tied 0 unless `OPDES_PARITY_EN`

## Operation
- **Shift register `shreg` (WIDTH bits):**
  - On each `ser_valid`, `shreg <= {ser_in, shreg[WIDTH-1:1]}`.
  - The first received bit ends up in `a_out[0]`.
- **Bit counter `cnt`:**
  - Range 0..FRAME-1, where FRAME = WIDTH, or WIDTH+1 with parity.
  - Increments only on `ser_valid`.
  - Wraps to 0 when the last frame bit is accepted.
  - A cycle with `ser_valid=0` holds both `cnt` and `shreg`; gaps of any length are legal.
- **Completion:** the last frame bit is accepted when `ser_valid && cnt==FRAME-1`.
- **Output register FSM, two states:**
  - `EMPTY` → `FULL` on completion.
  - `FULL` → `EMPTY` on `a_valid && a_ready` with no completion in the same cycle.
  - `FULL` stays `FULL` on completion together with `a_ready`: the new word is loaded and there is no bubble.
  - `FULL` on completion with `a_ready=0`: the new word is discarded, the held word is kept, and `overrun` pulses.
- **Handshake:**
  - `a_out` is stable while `a_valid && !a_ready`.
  - `a_valid` never drops without a transfer, except on `rst`.
- **Reset values:**
  - `a_out`=0, `a_valid`=0, `busy`=0, `overrun`=0, `parity_err`=0.
  - `cnt`=0, `shreg`=0, FSM in `EMPTY`.
- **Reset mid-word:** the partial word and any held word are discarded. The next accepted bit is bit 0 of a new frame.

## Timing
- `a_valid` rises the cycle after the last frame bit is sampled.
- Back-to-back frames with `ser_valid` held high give one word every FRAME cycles.
- `overrun` and `parity_err` pulse in the cycle after the offending completion.
- `busy` reflects `cnt ≠ 0` as a registered value; it is 0 in the cycle after completion.
- Throughput is limited only by the serial rate. `a_ready` may be held high permanently.

## Configuration
- **`OPDES_PARITY_EN` defined:**
  - FRAME = WIDTH+1. The extra bit received after the data is an even-parity bit.
  - The word is loaded only if XOR(data, parity bit) = 0.
  - On mismatch: the word is discarded, `parity_err` pulses, and the FSM state is unchanged.
  - A parity-failed word never raises `overrun`.
- **`OPDES_PARITY_EN` undefined:**
  - FRAME = WIDTH, no parity bit, and `parity_err` is constant 0.

## Structure
- **Shared package `shift_pkg`:**
  - `SHIFT_WIDTH` constant (8), shared with the shift stage.
  - Output FSM state typedef (`EMPTY`, `FULL`).
  - `FRAME` length derivation.
- **Sub-module `opdes_bitcnt`:** counter with enable, wrap, and terminal-count flag, parameterized by FRAME.
- **Top module:** `shreg`, the output register, the FSM, and parity logic.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` for 2 cycles with `ser_valid`=1 and random `ser_in`.
  - Required: all outputs 0 and `busy`=0 throughout; after release, the first bit starts a fresh frame.
- **Basic word:**
  - Stimulus: `a_ready`=1; send bits 1,0,1,0,0,1,0,1 on consecutive cycles 0–7.
  - Required: `a_valid`=1 with `a_out`=8'hA5 in cycle 8 only.
- **Gapped input:**
  - Stimulus: send 8'h3C with `ser_valid` low for 3 cycles between each bit.
  - Required: `a_out`=8'h3C; `busy` high from the first bit until completion.
- **Overrun:**
  - Stimulus: `a_ready`=0; send 8'h3C, then 8'hC3.
  - Required: `overrun` pulses once and `a_out` stays 8'h3C. Raising `a_ready` transfers 8'h3C, then `a_valid`=0.
- **Simultaneous complete and consume:**
  - Stimulus: hold 8'h11; assert `a_ready` in the exact cycle 8'h22 completes.
  - Required: `a_out`=8'h22 the next cycle, `a_valid` stays 1, no `overrun`.
- **Reset mid-word and parity:**
  - Stimulus: pulse `rst` after 4 bits of 8'hFF, then send 8'h81.
  - Required: `a_out`=8'h81.
  - With `OPDES_PARITY_EN`: 8'h81 followed by parity bit 1 → `parity_err` pulse, `a_valid` stays 0.
